// File: rtl/inout_sram_arbiter.sv
// inout_sram_arbiter: two-requester round-robin arbiter and sequencer for the
// 384kB InOut SRAM (6 x 64kB banks, 16b words, word addresses 0x00000-0x2FFFF).
//
// Requester 0 is the DMA/bus loader, requester 1 is the CNN PE engine.
// One access is granted per cycle. The SRAM pins are driven combinationally
// from the grant (cycle T). The SRAM returns read data one cycle later (T+1),
// and the response is registered (T+2). Out-of-range requests are handshaken
// normally but never touch the SRAM; they answer with rsp_err=1 and zero data.
//
// Build option: define INOUT_ARB_FIXED_PRIO_EN for fixed priority. Port 1
// then always wins a collision and no round-robin state exists.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/ready [1:0]         per-requester handshake
//   req_we/addr/wdata [1:0]       per-requester command
//   rsp_valid [1:0]               one-cycle response pulse per requester
//   rsp_rdata, rsp_err            shared response data / range-error flag
//   sram_CS/OE/WEB/A/DI           SRAM control, address and write data
//   sram_DO                       SRAM read data, valid the cycle after CS
module inout_sram_arbiter #(
    parameter int                ADDR_W     = 18,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(18'h30000)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_we,
    input  logic [1:0][ADDR_W-1:0]      req_addr,
    input  logic [1:0][DATA_W-1:0]      req_wdata,
    output logic [1:0]                  rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        sram_CS,
    output logic                        sram_OE,
    output logic                        sram_WEB,
    output logic [ADDR_W-1:0]           sram_A,
    output logic [DATA_W-1:0]           sram_DI,
    input  logic [DATA_W-1:0]           sram_DO
);

    // Grant for the current cycle
    logic              gnt_vld;
    logic              gnt_idx;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              g_in_rng;

    // Stage 1: access issued to the SRAM last cycle
    logic s1_valid_q, s1_valid_d;
    logic s1_port_q,  s1_port_d;
    logic s1_we_q,    s1_we_d;
    logic s1_err_q,   s1_err_d;
    logic oe_q,       oe_d;

    // Stage 2: registered response
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

`ifndef INOUT_ARB_FIXED_PRIO_EN
    logic rr_last_q, rr_last_d;
`endif

    // Arbitration; nothing is granted while reset is asserted
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (!rst) begin
            case (req_valid)
                2'b01: begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b0;
                end
                2'b10: begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b1;
                end
                2'b11: begin
                    gnt_vld = 1'b1;
`ifdef INOUT_ARB_FIXED_PRIO_EN
                    gnt_idx = 1'b1;
`else
                    gnt_idx = ~rr_last_q;
`endif
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt_idx = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        g_we     = req_we[gnt_idx];
        g_addr   = req_addr[gnt_idx];
        g_wdata  = req_wdata[gnt_idx];
        g_in_rng = (g_addr < ADDR_LIMIT);
    end

    // SRAM pins follow the grant in the same cycle
    always_comb begin
        req_ready = 2'b00;
        sram_A    = '0;
        sram_DI   = '0;
        sram_CS   = 1'b0;
        if (gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
            sram_A             = g_addr;
            sram_DI            = g_wdata;
            sram_CS            = g_in_rng;
        end
        sram_WEB = ~(g_we & sram_CS);
    end

    // Next-state for the pipeline
    always_comb begin
        s1_valid_d = gnt_vld;
        s1_port_d  = s1_port_q;
        s1_we_d    = s1_we_q;
        s1_err_d   = s1_err_q;
        if (gnt_vld) begin
            s1_port_d = gnt_idx;
            s1_we_d   = g_we;
            s1_err_d  = ~g_in_rng;
        end
        // OE is asserted in the cycle the SRAM drives read data
        oe_d = gnt_vld & ~g_we & g_in_rng;

        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;
        if (s1_valid_q) begin
            rsp_valid_d[s1_port_q] = 1'b1;
            rsp_err_d              = s1_err_q;
            rsp_rdata_d            = (s1_we_q | s1_err_q) ? '0 : sram_DO;
        end
`ifndef INOUT_ARB_FIXED_PRIO_EN
        rr_last_d = gnt_vld ? gnt_idx : rr_last_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_port_q   <= 1'b0;
            s1_we_q     <= 1'b0;
            s1_err_q    <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifndef INOUT_ARB_FIXED_PRIO_EN
            // Port 0 wins the first collision
            rr_last_q   <= 1'b1;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_port_q   <= s1_port_d;
            s1_we_q     <= s1_we_d;
            s1_err_q    <= s1_err_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifndef INOUT_ARB_FIXED_PRIO_EN
            rr_last_q   <= rr_last_d;
`endif
        end
    end

    assign sram_OE   = oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/inout_sram_arbiter.md
Name: inout_sram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 384kB InOut SRAM (6 x 64kB banks, 16b words, 18b word address, valid range 0x00000–0x2FFFF).
- Requester 0 is the DMA/bus loader; requester 1 is the CNN PE engine.
- Grants one access per cycle, round-robin. Drives the SRAM CS/OE/WEB/A/DI pins, accounting for the SRAM's registered bank select and 1-cycle read data.
- Returns read data or write acks with fixed latency; out-of-range addresses are rejected without touching the SRAM.

Parameters:
ADDR_W, 18, word address width
DATA_W, 16, data width
ADDR_LIMIT, 18'h30000, first invalid word address (6 banks x 32768 words)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  [1:0]  per-requester request valid
req_ready  output  [1:0]  per-requester grant; handshake = valid & ready
req_we  input  [1:0]  1 = write, 0 = read
req_addr  input  [1:0][ADDR_W-1:0]  word address
req_wdata  input  [1:0][DATA_W-1:0]  write data
rsp_valid  output  [1:0]  one-cycle response pulse
rsp_rdata  output  [DATA_W-1:0]  read data (shared bus; qualified by rsp_valid)
rsp_err  output  1  out-of-range flag for the current response
sram_CS  output  1  SRAM chip select
sram_OE  output  1  SRAM output enable
sram_WEB  output  1  SRAM write enable, active low
sram_A  output  ADDR_W  SRAM address
sram_DI  output  DATA_W  SRAM write data
sram_DO  input  DATA_W  SRAM read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, sram_CS=0, sram_OE=0, sram_WEB=1, sram_A=0, sram_DI=0, rr_last=1 (port 0 wins first). All pipeline valid bits are cleared.
- Arbitration (combinational, cycle T):
  - Only one valid: that port is granted.
  - Both valid: the port != rr_last is granted.
  - None valid: no grant.
  - req_ready is 0 whenever rst=1.
  - rr_last updates to the granted index at the clock edge of any handshake. It holds otherwise.
- SRAM drive in cycle T (combinational from grant):
  - sram_A and sram_DI = granted port's addr/wdata.
  - sram_CS = grant & (addr < ADDR_LIMIT).
  - sram_WEB = ~(we & CS).
  - With no grant: CS=0, WEB=1, A/DI hold 0.
- Stage 1 (T+1):
  - Registered s1_valid, s1_port, s1_we and s1_err = (addr >= ADDR_LIMIT).
  - sram_OE = s1_valid & ~s1_we & ~s1_err (registered, not combinational).
- Stage 2 (T+2):
  - rsp_valid[s1_port] pulses for one cycle.
  - Read: rsp_rdata = sram_DO captured at the T+1→T+2 edge.
  - Write or error: rsp_rdata=0.
  - rsp_err = s1_err.
  - rsp_rdata holds its last value when rsp_valid=0.
- Latency and throughput:
  - Fixed 2 cycles from handshake to response.
  - One new access accepted every cycle, reads and writes mixed, no bubbles.
- Ordering: responses are returned in grant order. Responses cannot be back-pressured; requesters must sink them.
- Read-after-write to the same address in consecutive cycles returns the new data, since the SRAM write commits at the T edge.
- Out-of-range: no SRAM access at all (CS=0, OE=0). The requester still gets a normal handshake and rsp_err=1 at T+2.
- Reset mid-operation: in-flight stage-1/stage-2 entries are dropped and no rsp_valid is issued for them. The SRAM contents are not affected by the arbiter.

Optional Feature:
- Macro: INOUT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 1 (PE) always wins when both are valid. rr_last is not implemented.
- Undefined: round-robin as specified above.
- Latency and error behaviour are identical in both builds.

Test Plan:
- Reset then port0 write 0x00005=0xBEEF, next cycle port0 read 0x00005 -> ready same cycle; write ack rsp_valid[0] at T+2 with err=0; read rsp_rdata=0xBEEF at T+3; sram_OE high only in the read's T+1.
- Both ports request reads continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; responses arrive in the same order, 2 cycles after each grant.
- Bank crossing: write 0x07FFF=0x1111 and 0x08000=0x2222, then read both back -> 0x1111 and 0x2222 with no corruption; sram_A matches each request.
- Port1 read 0x30000 and write 0x3FFFF -> sram_CS stays 0 and sram_OE stays 0; rsp_valid[1] with rsp_err=1 and rdata=0x0000 at T+2.
- Read issued at T, rst asserted at T+1 -> no rsp_valid ever for that read; all outputs at reset values; first post-reset contention is won by port 0 (or by port 1 with INOUT_ARB_FIXED_PRIO_EN).
